// File: rtl/ic0_arbiter.sv
// ic0_arbiter: two-master round-robin arbiter for the ic0 bus with a single
// outstanding read, response routing and read timeout.
module ic0_arbiter #(
    parameter int          SEL_LO   = 12,
    parameter int          TIMEOUT  = 15,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        c_sys_rst,
    input  logic        m0_c_rd_req,
    input  logic        m0_c_wr_req,
    input  logic [31:0] m0_rd_addr,
    input  logic [31:0] m0_wr_addr,
    input  logic [31:0] m0_wr_data,
    input  logic [3:0]  m0_wr_strobe,
    output logic        m0_c_gnt,
    output logic        m0_c_rd_done,
    output logic        m0_c_rd_err,
    output logic [31:0] m0_rd_data,
    input  logic        m1_c_rd_req,
    input  logic        m1_c_wr_req,
    input  logic [31:0] m1_rd_addr,
    input  logic [31:0] m1_wr_addr,
    input  logic [31:0] m1_wr_data,
    input  logic [3:0]  m1_wr_strobe,
    output logic        m1_c_gnt,
    output logic        m1_c_rd_done,
    output logic        m1_c_rd_err,
    output logic [31:0] m1_rd_data,
    output logic        ic0_c_axi_mst_wr_valid,
    output logic        ic0_c_axi_mst_rd_valid,
    output logic [31:0] ic0_axi_mst_wr_addr,
    output logic [31:0] ic0_axi_mst_rd_addr,
    output logic [31:0] ic0_axi_mst_wr_data,
    output logic [3:0]  ic0_axi_mst_wr_strobe,
    input  logic        ic0_c_axi_slv_rd_ready_0,
    input  logic        ic0_c_axi_slv_rd_ready_1,
    input  logic        ic0_c_axi_slv_rd_ready_2,
    input  logic [31:0] ic0_axi_slv_rd_data_0,
    input  logic [31:0] ic0_axi_slv_rd_data_1,
    input  logic [31:0] ic0_axi_slv_rd_data_2
);
    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_ERR} state_t;

    state_t      state_q, state_d;
    logic        last_q, last_d, owner_q, owner_d;
    logic [1:0]  sel_q, sel_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        done_q, done_d, err_q, err_d;
    logic [31:0] data_q, data_d;

    logic        req0, req1, win, any, w_wr, rdy, resp_done, resp_err;
    logic [1:0]  w_sel;
    logic [31:0] w_rd_addr, slv_data, resp_data;

    // Arbitration; reset gating keeps every output low while c_sys_rst is asserted.
    always_comb begin
        req0      = m0_c_rd_req | m0_c_wr_req;
        req1      = m1_c_rd_req | m1_c_wr_req;
        win       = (req0 && req1) ? ~last_q : req1;
        any       = c_sys_rst && state_q == IDLE && (req0 || req1);
        w_wr      = win ? m1_c_wr_req : m0_c_wr_req;
        w_rd_addr = win ? m1_rd_addr : m0_rd_addr;
        w_sel     = w_rd_addr[SEL_LO+1:SEL_LO];
        rdy       = sel_q == 2'd0 ? ic0_c_axi_slv_rd_ready_0 :
                    sel_q == 2'd1 ? ic0_c_axi_slv_rd_ready_1 :
                    sel_q == 2'd2 ? ic0_c_axi_slv_rd_ready_2 : 1'b0;
        slv_data  = sel_q == 2'd0 ? ic0_axi_slv_rd_data_0 :
                    sel_q == 2'd1 ? ic0_axi_slv_rd_data_1 : ic0_axi_slv_rd_data_2;
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        data_d  = '0;
        case (state_q)
            IDLE: if (any) begin
                last_d = win;
                if (!w_wr) begin
                    owner_d = win;
                    sel_d   = w_sel;
                    cnt_d   = '0;
                    state_d = w_sel == 2'd3 ? RD_ERR : RD_WAIT;
                end
            end
            // Ready is checked before the timeout so a same-cycle ready wins.
            RD_WAIT: if (rdy) begin
                state_d = IDLE;
                done_d  = 1'b1;
                data_d  = slv_data;
            end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                state_d = IDLE;
                done_d  = 1'b1;
                err_d   = 1'b1;
                data_d  = ERR_DATA;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge c_sys_rst) begin
        if (!c_sys_rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            sel_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        m0_c_gnt               = any && !win;
        m1_c_gnt               = any && win;
        ic0_c_axi_mst_wr_valid = any && w_wr;
        ic0_c_axi_mst_rd_valid = any && !w_wr && w_sel != 2'd3;
        ic0_axi_mst_wr_addr    = (any && w_wr) ? (win ? m1_wr_addr : m0_wr_addr) : '0;
        ic0_axi_mst_wr_data    = (any && w_wr) ? (win ? m1_wr_data : m0_wr_data) : '0;
        ic0_axi_mst_wr_strobe  = (any && w_wr) ? (win ? m1_wr_strobe : m0_wr_strobe) : '0;
        ic0_axi_mst_rd_addr    = (any && !w_wr) ? w_rd_addr : '0;
        resp_done              = done_q || state_q == RD_ERR;
        resp_err               = err_q || state_q == RD_ERR;
        resp_data              = state_q == RD_ERR ? ERR_DATA : data_q;
        m0_c_rd_done           = resp_done && !owner_q;
        m0_c_rd_err            = resp_err && !owner_q;
        m0_rd_data             = (resp_done && !owner_q) ? resp_data : '0;
        m1_c_rd_done           = resp_done && owner_q;
        m1_c_rd_err            = resp_err && owner_q;
        m1_rd_data             = (resp_done && owner_q) ? resp_data : '0;
    end
endmodule
